// File: rtl/cdc_xfer_arb.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel among NUM_REQ requesters.
// Optional REQ/REL watchdog with timeout_err output: define CDC_XFER_ARB_TIMEOUT_EN.

module cdc_sync #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  // Plain flop chain, deliberately without reset.
  logic [N-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];
endmodule

module cdc_xfer_arb #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     xfer_req,
  output logic [WIDTH-1:0]         xfer_data,
  input  logic                     xfer_ack,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
`ifdef CDC_XFER_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_REL   = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;
  localparam logic [1:0] ST_REQ   = 2'd3;

  localparam int unsigned FL_W = $clog2(SYNC_STAGES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("cdc_xfer_arb: illegal parameter value");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  w_grant_nxt;
  logic [WIDTH-1:0] r_xfer_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_xfer_req;
  logic [FL_W-1:0]  r_flush_cnt;
  logic [FL_W-1:0]  w_flush_nxt;
  logic [NUM_REQ-1:0] w_req_ready;
  logic             w_ack_s;
  logic [WIDTH-1:0] w_lane [NUM_REQ];

  cdc_sync #(.N(SYNC_STAGES), .WIDTH(1)) u_ack_sync (
    .clk (clk),
    .i_d (xfer_ack),
    .o_q (w_ack_s)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_lane[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // First valid requester at or above the RR pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    w_win = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 32'(r_ptr) + 32'(k);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[ID_W'(idx)]) w_win = ID_W'(idx);
    end
  end

`ifdef CDC_XFER_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_wdog;
  logic [TO_W-1:0] w_wdog_nxt;
  logic            r_timeout_err;
  logic            w_tmo_nxt;
  logic            w_wdog_hit;

  assign w_wdog_hit = (r_wdog == TO_W'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant_id;
    w_data_nxt  = r_xfer_data;
    w_flush_nxt = r_flush_cnt;
    w_req_ready = '0;
    case (r_state)
      ST_FLUSH: begin
        if (r_flush_cnt == FL_W'(SYNC_STAGES - 1)) begin
          w_state_nxt = ST_REL;
          w_flush_nxt = '0;
        end else begin
          w_flush_nxt = r_flush_cnt + FL_W'(1);
        end
      end
      ST_IDLE: begin
        if (|req_valid) begin
          w_req_ready[w_win] = 1'b1;
          w_data_nxt         = w_lane[w_win];
          w_grant_nxt        = w_win;
          w_ptr_nxt          = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
          w_state_nxt        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_ack_s) begin
          w_state_nxt = ST_REL;
`ifdef CDC_XFER_ARB_TIMEOUT_EN
        end else if (w_wdog_hit) begin
          w_state_nxt = ST_REL;
`endif
        end
      end
      ST_REL: begin
        if (!w_ack_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_FLUSH;
    endcase
  end

`ifdef CDC_XFER_ARB_TIMEOUT_EN
  // Watchdog clears on any state change; restarts after expiring while parked in REL.
  always_comb begin
    w_wdog_nxt = '0;
    w_tmo_nxt  = 1'b0;
    if (w_state_nxt == r_state && (r_state == ST_REQ || r_state == ST_REL)) begin
      w_wdog_nxt = w_wdog_hit ? '0 : r_wdog + TO_W'(1);
      w_tmo_nxt  = (w_wdog_nxt == TO_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wdog        <= w_wdog_nxt;
      r_timeout_err <= w_tmo_nxt;
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FLUSH;
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_xfer_data <= '0;
      r_xfer_req  <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant_id  <= w_grant_nxt;
      r_xfer_data <= w_data_nxt;
      r_xfer_req  <= (w_state_nxt == ST_REQ);
      r_flush_cnt <= w_flush_nxt;
    end
  end

  assign req_ready = w_req_ready;
  assign xfer_req  = r_xfer_req;
  assign xfer_data = r_xfer_data;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

endmodule
